apple_placement_ctrl: RTL and testbench
=======================================

# apple_placement_ctrl

Sequencer that places a new apple after the snake eats one. It detects each rising edge of the good-collision flag, samples a random board coordinate, and walks the snake body one segment per cycle through a shared read port to reject occupied cells. It retries until a free cell is found, then commits the coordinate that the apple pixel logic and renderer consume. It sits between the collision checker, the random source and the body register file.

## Interface
- MAX_LEN, 50: body register depth; also the ceiling for body_len.
- RETRY_MAX, 15: random attempts before switching to sequential search.
- INIT_APPLE, 8'hC5: apple coordinate {x,y} after reset.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- good_coll  in  1  level flag from the collision checker; high while the head is on the apple.
- rand_x, rand_y  in  4 each  free-running random source, sampled in SAMPLE.
- body_len  in  6  number of valid segments; values above MAX_LEN are clamped to MAX_LEN.
- body_idx  out  6  segment index being read.
- body_seg  in  8  {x,y} of body[body_idx], combinational in the same cycle.
- x, y  in  4 each  current scan pixel from the display.
- apple_cord  out  8  committed apple {x,y}.
- apple_valid  out  1  apple_cord is placed and live.
- apple  out  1  registered pixel hit: {x,y}==apple_cord && apple_valid.
- busy  out  1  state != IDLE.
- fallback  out  1  one-cycle pulse when the controller enters sequential search.

## Operation
- Edge detect: gc_q1 <= good_coll; gc_q2 <= gc_q1; rise = gc_q1 & ~gc_q2. A rise while busy is dropped; while busy, no apple exists to eat.
- FSM states:
  - IDLE (apple_valid=1).
    - On rise: go to SAMPLE, apple_valid <= 0, retry_cnt <= 0, seq_mode <= 0.
  - SAMPLE.
    - cand <= {rand_x,rand_y}, idx <= 0.
    - If the clamped body_len == 0, go to COMMIT; otherwise go to SCAN.
  - SCAN.
    - Drive body_idx = idx and compare body_seg to cand.
    - Match with seq_mode=0 and retry_cnt < RETRY_MAX-1: retry_cnt++, go to SAMPLE.
    - Match with seq_mode=0 and retry_cnt == RETRY_MAX-1: seq_mode <= 1, fallback pulse, cand <= cand+1 (mod 256), idx <= 0, stay in SCAN.
    - Match with seq_mode=1: cand <= cand+1 (mod 256), idx <= 0, stay in SCAN.
    - No match and idx == len-1: go to COMMIT.
    - No match otherwise: idx++.
  - COMMIT.
    - apple_cord <= cand, apple_valid <= 1, go to IDLE.
- body_idx = 0 outside SCAN.
- Sequential search terminates because MAX_LEN < 256 cells. At most MAX_LEN+1 candidates are tried.
- busy = (state != IDLE).
- Reset values: state IDLE, apple_cord INIT_APPLE, apple_valid 1, apple 0, fallback 0, busy 0, body_idx 0, gc_q1 0, gc_q2 0, retry_cnt 0, seq_mode 0.

## Timing
- good_coll rises before edge 0:
  - Edge 1: SAMPLE, apple_valid=0.
  - Edge 2: SCAN.
  - Edge 2+L: COMMIT.
  - Edge 3+L: apple_valid=1, new apple_cord.
- Clean-placement latency is therefore L+3 cycles from the gc_q1 edge.
- Each random retry adds 1 (SAMPLE) + k cycles, where the match occurs at index k-1.
- apple lags {x,y} by 1 cycle. It is 0 whenever apple_valid=0.
- good_coll held high for many cycles produces exactly one rise.
- Reset asserted mid-operation wins on that edge: the next cycle shows reset values, and any in-flight search is discarded.
- body_len changing during SCAN: the new value is used from the next comparison. The body is always sampled live.

## Structure
- The shared package snake_pkg holds:
  - typedef coord_t (logic [7:0], {x,y})
  - MAX_LEN
  - INIT_APPLE
  - typedef enum place_state_t {IDLE, SAMPLE, SCAN, COMMIT}
- One sub-module, rise_detect: the two-flop shift and edge AND. It is reusable for other collision flags.
- Body storage stays outside this block; the block only uses the body_idx/body_seg port.

## Test plan
- Reset, then no stimulus → apple_cord=8'hC5, apple_valid=1, busy=0. x=4'hC, y=4'h5 gives apple=1 one cycle later.
- body_len=3, body={8'h11,8'h12,8'h13}, rand=8'h77, one good_coll pulse → apple_valid low for edges 1..5, apple_cord=8'h77 at edge 6.
- Same body, rand=8'h12 for the first SAMPLE, then 8'h40 → one retry; apple_cord=8'h40; fallback never pulses.
- rand stuck at 8'h11 with body[0]=8'h11, body[1]=8'h12 → after 15 attempts, fallback pulses once; candidates 12h then 13h follow; apple_cord=8'h13.
- good_coll held high 20 cycles, plus a second rise injected while busy → exactly one placement; busy drops after one COMMIT.
- reset pulsed while in SCAN → the next cycle shows state IDLE, apple_cord=8'hC5, apple_valid=1; body_len=0 with a rise → commit at edge 3 with cand=rand.

Source files
------------

// File: rtl/snake_pkg.sv
// snake_pkg: shared types and constants for the snake game blocks
package snake_pkg;
  typedef logic [7:0] coord_t;
  localparam int MAX_LEN = 50;
  localparam coord_t INIT_APPLE = 8'hC5;
  typedef enum logic [1:0] {IDLE, SAMPLE, SCAN, COMMIT} place_state_t;
endpackage

// File: rtl/apple_placement_ctrl_if.sv
// apple_placement_ctrl_if: collision, random, body-port and apple signals of the placement controller
interface apple_placement_ctrl_if;
  import snake_pkg::*;
  logic good_coll;
  logic [3:0] rand_x, rand_y, x, y;
  logic [5:0] body_len, body_idx;
  coord_t body_seg, apple_cord;
  logic apple_valid, apple, busy, fallback;
  modport master (
    input good_coll, rand_x, rand_y, body_len, body_seg, x, y,
    output body_idx, apple_cord, apple_valid, apple, busy, fallback
  );
  modport slave (
    output good_coll, rand_x, rand_y, body_len, body_seg, x, y,
    input body_idx, apple_cord, apple_valid, apple, busy, fallback
  );
endinterface

// File: rtl/rise_detect.sv
// rise_detect: two-flop shift of a level flag with a one-cycle rising-edge pulse
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic q1, q2;
  always_ff @(posedge clk)
    if (reset) {q1, q2} <= 2'b00;
    else {q1, q2} <= {d, q1};
  assign rise = q1 & ~q2;
endmodule

// File: rtl/apple_placement_ctrl.sv
// apple_placement_ctrl: picks a free board cell for the next apple by scanning the snake body
module apple_placement_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned RETRY_MAX = 15
) (
  input logic clk,
  input logic reset,
  apple_placement_ctrl_if.master bus
);
  place_state_t state;
  coord_t cand;
  logic [5:0] idx, len;
  logic [3:0] retry_cnt;
  logic seq_mode, rise, hit, last;
  rise_detect u_rise (.clk(clk), .reset(reset), .d(bus.good_coll), .rise(rise));
  assign len = bus.body_len > 6'(MAX_LEN) ? 6'(MAX_LEN) : bus.body_len;
  assign hit = bus.body_seg == cand;
  // wider compare also ends the scan if body_len shrinks below idx mid-search
  assign last = 7'(idx) + 7'd1 >= 7'(len);
  assign bus.body_idx = state == SCAN ? idx : 6'd0;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cand <= '0;
      idx <= '0;
      retry_cnt <= '0;
      seq_mode <= 1'b0;
      bus.apple_cord <= INIT_APPLE;
      bus.apple_valid <= 1'b1;
      bus.apple <= 1'b0;
      bus.fallback <= 1'b0;
    end else begin
      bus.fallback <= 1'b0;
      bus.apple <= {bus.x, bus.y} == bus.apple_cord && bus.apple_valid && !(state == IDLE && rise);
      case (state)
        IDLE: if (rise) begin
          state <= SAMPLE;
          bus.apple_valid <= 1'b0;
          retry_cnt <= '0;
          seq_mode <= 1'b0;
        end
        SAMPLE: begin
          cand <= {bus.rand_x, bus.rand_y};
          idx <= '0;
          state <= len == 6'd0 ? COMMIT : SCAN;
        end
        SCAN: if (hit && !seq_mode && retry_cnt < 4'(RETRY_MAX - 1)) begin
          retry_cnt <= retry_cnt + 4'd1;
          state <= SAMPLE;
        end else if (hit) begin
          seq_mode <= 1'b1;
          bus.fallback <= !seq_mode;
          cand <= cand + 8'd1;
          idx <= '0;
        end else if (last) state <= COMMIT;
        else idx <= idx + 6'd1;
        COMMIT: begin
          bus.apple_cord <= cand;
          bus.apple_valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apple_placement_ctrl.sv
// tb_apple_placement_ctrl: timeline model of apple placement checked against the DUT every cycle
module tb_apple_placement_ctrl;
  import snake_pkg::*;
  localparam int N = 9000, NSEG = 32, RETRY = 15;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  apple_placement_ctrl_if bus();
  apple_placement_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  logic [7:0] bodies [NSEG][64];
  int cur = 0;
  assign bus.body_seg = bodies[cur][bus.body_idx];
  // stimulus per edge n (driven just before edge n), expectations/logs per edge n (just after it)
  logic r_a [N], g_a [N], xy_fix [N];
  logic [7:0] rnd_a [N], xy_a [N];
  logic [5:0] len_a [N];
  int seg_a [N];
  logic [7:0] e_cord [N], l_cord [N];
  logic e_valid [N], e_busy [N], e_fb [N], e_apple [N];
  logic l_valid [N], l_busy [N], l_fb [N], l_apple [N];
  int n_chk = 0, n_fail = 0, pos = 0, nseg = 0;
  logic [5:0] c_len = 0;
  int b1, b2, b3, b4, g0, g1, g3, g4, g5, rs4, p_apple;

  function automatic void step(input logic g, input logic [7:0] r, input logic rs = 1'b0);
    if (pos >= N) return;
    r_a[pos] = rs; g_a[pos] = g; rnd_a[pos] = r; len_a[pos] = c_len; seg_a[pos] = nseg;
    pos++;
  endfunction

  function automatic void body3(input int s);
    for (int i = 0; i < 64; i++) bodies[s][i] = 8'($urandom);
    bodies[s][0] = 8'h11; bodies[s][1] = 8'h12; bodies[s][2] = 8'h13;
  endfunction

  function automatic void build();
    int l;
    logic gv, spc;
    logic [7:0] r;
    for (int n = 0; n < N; n++) xy_fix[n] = 1'b0;
    nseg = 0; body3(0); c_len = 3;
    step(0, 8'h77, 1); step(0, 8'h77, 1);
    p_apple = pos + 1;
    for (int k = 0; k < 4; k++) begin xy_fix[pos] = 1'b1; xy_a[pos] = 8'hC5; step(0, 8'h77); end
    g0 = pos; step(1, 8'h77);
    for (int k = 0; k < 10; k++) step(0, 8'h77);
    nseg = 1; body3(1); b1 = pos;
    step(0, 8'h40, 1); step(0, 8'h40, 1); step(0, 8'h40); step(0, 8'h40);
    g1 = pos; step(1, 8'h40); step(0, 8'h40); step(0, 8'h12);
    for (int k = 0; k < 15; k++) step(0, 8'h40);
    nseg = 2; body3(2); c_len = 2; b2 = pos;
    step(0, 8'h11, 1); step(0, 8'h11, 1); step(1, 8'h11);
    for (int k = 0; k < 60; k++) step(0, 8'h11);
    nseg = 3; body3(3); c_len = 3; b3 = pos;
    step(0, 8'h77, 1); step(0, 8'h77, 1);
    g3 = pos;
    for (int k = 0; k < 22; k++) step(k != 3, 8'h77);
    for (int k = 0; k < 8; k++) step(0, 8'h77);
    nseg = 4; body3(4); b4 = pos;
    step(0, 8'h77, 1); step(0, 8'h77, 1); step(0, 8'h77);
    g4 = pos; step(1, 8'h77); step(0, 8'h77); step(0, 8'h77);
    rs4 = pos; c_len = 0; step(0, 8'h77, 1);
    step(0, 8'h5A); step(0, 8'h5A);
    g5 = pos; step(1, 8'h5A);
    for (int k = 0; k < 8; k++) step(0, 8'h5A);
    for (int s = 5; s < NSEG && pos < N - 700; s++) begin
      nseg = s; spc = s == 6;
      c_len = spc ? 6'd20 : ($urandom % 8 == 0 ? 6'($urandom_range(51, 63)) : 6'($urandom_range(0, 50)));
      l = c_len > 6'(MAX_LEN) ? MAX_LEN : int'(c_len);
      for (int i = 0; i < 64; i++) bodies[s][i] = spc ? 8'(8'h30 + i) : 8'($urandom);
      step(0, 8'h00, 1); step(0, 8'h00, 1);
      gv = 1'b0;
      for (int k = 0; k < (spc ? 600 : 400); k++) begin
        gv = gv ? ($urandom % 4 != 0) : ($urandom % 8 == 0);
        r = (l > 0 && (spc || $urandom % 2 == 0)) ? bodies[s][$urandom_range(0, l - 1)] : 8'($urandom);
        step(gv, r, $urandom % 500 == 0);
      end
    end
    while (pos < N) step(0, 8'($urandom));
  endfunction

  function automatic int find(input int sg, input int l, input logic [7:0] c);
    for (int i = 0; i < l; i++) if (bodies[sg][i] == c) return i;
    return -1;
  endfunction

  // SAMPLE occupies the cycle after edge s; returns edge e where the apple becomes valid
  function automatic void place(input int s, output int e, output logic [7:0] c, output int fbe);
    int t, k, l, sg, tries;
    t = s; tries = 0; fbe = -1; e = N + 100; c = 8'h00;
    if (s + 1 >= N) return;
    l = len_a[s + 1] > 6'(MAX_LEN) ? MAX_LEN : int'(len_a[s + 1]);
    sg = seg_a[s];
    while (t + 1 < N && tries < RETRY) begin
      c = rnd_a[t + 1];
      k = l == 0 ? -1 : find(sg, l, c);
      if (k < 0) begin e = t + 2 + l; return; end
      t += 2 + k;
      tries++;
    end
    if (tries < RETRY) return;
    fbe = t;
    for (int j = 0; j < 256 && t < N; j++) begin
      c = c + 8'd1;
      k = find(sg, l, c);
      if (k < 0) begin e = t + l + 1; return; end
      t += k + 1;
    end
  endfunction

  function automatic void model();
    logic pend, q1, rise;
    logic [7:0] cord, pc;
    int st, e_end, fbe;
    pend = 0; q1 = 0; cord = INIT_APPLE; pc = 0; st = 0; e_end = 0; fbe = -1;
    for (int n = 0; n < N; n++) begin
      if (r_a[n]) begin
        pend = 0; q1 = 0; cord = INIT_APPLE;
        e_busy[n] = 0; e_fb[n] = 0;
      end else begin
        if (pend && n == e_end) begin pend = 0; cord = pc; end
        e_busy[n] = pend && n >= st;
        e_fb[n] = pend && n == fbe;
        rise = g_a[n] && !q1; q1 = g_a[n];
        if (!pend && rise) begin pend = 1; st = n + 1; place(st, e_end, pc, fbe); end
      end
      e_valid[n] = !e_busy[n];
      e_cord[n] = cord;
    end
    for (int n = 0; n < N; n++) begin
      if (!xy_fix[n]) xy_a[n] = ($urandom % 2 == 0 && n > 0) ? e_cord[n - 1] : 8'($urandom);
      e_apple[n] = !r_a[n] && n > 0 && xy_a[n] == e_cord[n - 1] && e_valid[n - 1] && e_valid[n];
    end
  endfunction

  task automatic cmp(input string nm, input int n, input logic [7:0] got, input logic [7:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %h, want %h", nm, n, got, want);
    end
  endtask

  task automatic check(input int n);
    l_cord[n] = bus.apple_cord; l_valid[n] = bus.apple_valid; l_busy[n] = bus.busy;
    l_fb[n] = bus.fallback; l_apple[n] = bus.apple;
    cmp("apple_cord", n, l_cord[n], e_cord[n]);
    cmp("apple_valid", n, 8'(l_valid[n]), 8'(e_valid[n]));
    cmp("busy", n, 8'(l_busy[n]), 8'(e_busy[n]));
    cmp("fallback", n, 8'(l_fb[n]), 8'(e_fb[n]));
    cmp("apple", n, 8'(l_apple[n]), 8'(e_apple[n]));
    if (!e_busy[n]) cmp("body_idx_idle", n, 8'(bus.body_idx), 8'h00);
  endtask

  function automatic int count_fb(input int a, input int b, input logic dut_side);
    int c = 0;
    for (int i = a; i < b; i++) c += int'(dut_side ? l_fb[i] : e_fb[i]);
    return c;
  endfunction

  initial begin
    int rises;
    bus.good_coll = 0; bus.rand_x = 0; bus.rand_y = 0; bus.x = 0; bus.y = 0; bus.body_len = 0;
    build();
    model();
    for (int n = 0; n < N; n++) begin
      @(negedge clk);
      if (n > 0) check(n - 1);
      reset = r_a[n]; bus.good_coll = g_a[n]; {bus.rand_x, bus.rand_y} = rnd_a[n];
      {bus.x, bus.y} = xy_a[n]; bus.body_len = len_a[n]; cur = seg_a[n];
    end
    @(negedge clk);
    check(N - 1);
    cmp("lit_reset_cord", 1, l_cord[1], 8'hC5);
    cmp("lit_reset_valid", 1, 8'(l_valid[1]), 8'h01);
    cmp("lit_reset_busy", 1, 8'(l_busy[1]), 8'h00);
    cmp("lit_apple_hit", p_apple, 8'(l_apple[p_apple]), 8'h01);
    cmp("lit_clean_valid_lo1", g0 + 1, 8'(l_valid[g0 + 1]), 8'h00);
    cmp("lit_clean_valid_lo5", g0 + 5, 8'(l_valid[g0 + 5]), 8'h00);
    cmp("lit_clean_valid_hi", g0 + 6, 8'(l_valid[g0 + 6]), 8'h01);
    cmp("lit_clean_cord", g0 + 6, l_cord[g0 + 6], 8'h77);
    cmp("model_clean_cord", g0 + 6, e_cord[g0 + 6], 8'h77);
    cmp("lit_retry_cord", b2 - 1, l_cord[b2 - 1], 8'h40);
    cmp("lit_retry_no_fb", b1, 8'(count_fb(b1, b2, 1)), 8'h00);
    cmp("lit_fb_once", b2, 8'(count_fb(b2, b3, 1)), 8'h01);
    cmp("model_fb_once", b2, 8'(count_fb(b2, b3, 0)), 8'h01);
    cmp("lit_fb_cord", b3 - 1, l_cord[b3 - 1], 8'h13);
    cmp("model_fb_cord", b3 - 1, e_cord[b3 - 1], 8'h13);
    rises = 0;
    for (int i = b3 + 1; i < b4; i++) rises += int'(l_valid[i] && !l_valid[i - 1]);
    cmp("lit_held_one_place", g3, 8'(rises), 8'h01);
    cmp("lit_rst_mid_cord", rs4, l_cord[rs4], 8'hC5);
    cmp("lit_rst_mid_valid", rs4, 8'(l_valid[rs4]), 8'h01);
    cmp("lit_rst_mid_busy", rs4, 8'(l_busy[rs4]), 8'h00);
    cmp("lit_len0_busy", g5 + 2, 8'(l_valid[g5 + 2]), 8'h00);
    cmp("lit_len0_valid", g5 + 3, 8'(l_valid[g5 + 3]), 8'h01);
    cmp("lit_len0_cord", g5 + 3, l_cord[g5 + 3], 8'h5A);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
